// File: rtl/storage_readout_pkg.sv
// Shared definitions for the capture-storage drain engine: state encoding,
// channel-select codes and the default storage read latency.
package storage_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_SEND_LO = 3'd3,
    ST_SEND_HI = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  localparam logic [1:0] CH_A   = 2'd0;
  localparam logic [1:0] CH_B   = 2'd1;
  localparam logic [1:0] CH_ALT = 2'd2;

  localparam int RD_LAT_DEFAULT = 2;

  // The reserved select code behaves exactly like bank-A-only.
  function automatic logic [1:0] norm_mode(input logic [1:0] sel);
    logic [1:0] m;
    if (sel == 2'd3) begin
      m = CH_A;
    end else begin
      m = sel;
    end
    return m;
  endfunction

endpackage

// File: rtl/readout_byte_ser.sv
// Word hold register and two-beat (low byte, then high byte) valid/ready
// serialiser; flags the low-byte and the completing high-byte handshakes.
module readout_byte_ser
  import storage_readout_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] din,
  input  logic        flush,
  input  logic        byte_ready,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        lo_accepted,
  output logic        word_accepted
);

  logic [15:0] hold_q, hold_d;
  logic        valid_q, valid_d;
  logic        hi_q, hi_d;

  // Next hold/valid/phase; flush wins over a load or a handshake in the same cycle.
  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    hi_d    = hi_q;
    if (flush) begin
      valid_d = 1'b0;
      hi_d    = 1'b0;
    end else if (load) begin
      hold_d  = din;
      valid_d = 1'b1;
      hi_d    = 1'b0;
    end else if (valid_q && byte_ready) begin
      if (hi_q) begin
        valid_d = 1'b0;
        hi_d    = 1'b0;
      end else begin
        hi_d    = 1'b1;
      end
    end else begin
      hi_d    = hi_q;
    end
  end

  // Serialiser state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q  <= 16'h0000;
      valid_q <= 1'b0;
      hi_q    <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
    end
  end

  // Byte select comes straight from flops, so it cannot move while stalled.
  assign byte_out      = hi_q ? hold_q[15:8] : hold_q[7:0];
  assign byte_valid    = valid_q;
  assign lo_accepted   = valid_q && byte_ready && !hi_q;
  assign word_accepted = valid_q && byte_ready && hi_q;

endmodule

// File: rtl/storage_readout.sv
// Drain engine: strobes the dual-bank storage one word at a time and streams
// each returned word out as two bytes, low byte first.
module storage_readout
  import storage_readout_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic             rdclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       chan_sel,
  input  logic [CNT_W-1:0] sample_count,
  output logic             rdenA,
  output logic             rdenB,
  input  logic [15:0]      dout_in,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] words_read
);

  localparam int WCW = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] words_read_q, words_read_d;
  logic [1:0]       mode_q, mode_d;
  logic             bank_q, bank_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             aborted_q, aborted_d;
  logic             rdena_q, rdena_d;
  logic             rdenb_q, rdenb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic ser_load_s;
  logic ser_flush_s;
  logic lo_acc_s;
  logic word_acc_s;

  readout_byte_ser u_ser (
    .clk          (rdclk),
    .rst_n        (rst_n),
    .load         (ser_load_s),
    .din          (dout_in),
    .flush        (ser_flush_s),
    .byte_ready   (byte_ready),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .lo_accepted  (lo_acc_s),
    .word_accepted(word_acc_s)
  );

  // Drain sequencing, counters and bank selection.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    words_read_d = words_read_q;
    mode_d       = mode_q;
    bank_d       = bank_q;
    wait_cnt_d   = wait_cnt_q;
    aborted_d    = aborted_q;
    ser_load_s   = 1'b0;
    ser_flush_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d  = sample_count;
          mode_d       = norm_mode(chan_sel);
          words_read_d = {CNT_W{1'b0}};
          aborted_d    = 1'b0;
          bank_d       = (norm_mode(chan_sel) == CH_B);
          if (sample_count == {CNT_W{1'b0}}) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_FIN;
        end else begin
          wait_cnt_d = WCW'(RD_LAT - 1);
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_FIN;
        end else if (wait_cnt_q == {WCW{1'b0}}) begin
          ser_load_s = 1'b1;
          state_d    = ST_SEND_LO;
        end else begin
          wait_cnt_d = wait_cnt_q - WCW'(1);
        end
      end
      ST_SEND_LO: begin
        if (abort) begin
          ser_flush_s = 1'b1;
          aborted_d   = 1'b1;
          state_d     = ST_FIN;
        end else if (lo_acc_s) begin
          state_d = ST_SEND_HI;
        end else begin
          state_d = ST_SEND_LO;
        end
      end
      ST_SEND_HI: begin
        // A high-byte handshake coinciding with abort still completes the word.
        if (word_acc_s) begin
          words_read_d = words_read_q + CNT_W'(1);
          remaining_d  = remaining_q - CNT_W'(1);
          if (mode_q == CH_ALT) begin
            bank_d = !bank_q;
          end else begin
            bank_d = bank_q;
          end
          if (abort) begin
            aborted_d = 1'b1;
            state_d   = ST_FIN;
          end else if (remaining_q == CNT_W'(1)) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end else if (abort) begin
          ser_flush_s = 1'b1;
          aborted_d   = 1'b1;
          state_d     = ST_FIN;
        end else begin
          state_d = ST_SEND_HI;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered strobes and status, decoded from the state being entered.
  always_comb begin
    rdena_d = (state_d == ST_ISSUE) && !bank_d;
    rdenb_d = (state_d == ST_ISSUE) && bank_d;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_q == ST_FIN);
  end

  // Control and counter registers.
  always_ff @(posedge rdclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= {CNT_W{1'b0}};
      words_read_q <= {CNT_W{1'b0}};
      mode_q       <= CH_A;
      bank_q       <= 1'b0;
      wait_cnt_q   <= {WCW{1'b0}};
      aborted_q    <= 1'b0;
      rdena_q      <= 1'b0;
      rdenb_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      words_read_q <= words_read_d;
      mode_q       <= mode_d;
      bank_q       <= bank_d;
      wait_cnt_q   <= wait_cnt_d;
      aborted_q    <= aborted_d;
      rdena_q      <= rdena_d;
      rdenb_q      <= rdenb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rdenA      = rdena_q;
  assign rdenB      = rdenb_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign words_read = words_read_q;

endmodule

// File: tb/tb_storage_readout.sv
// Directed bench for storage_readout with a two-cycle-latency dual-bank
// storage model and a byte-stream collector.
module tb_storage_readout;

  logic        rdclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  chan_sel = 2'd0;
  logic [15:0] sample_count = 16'd0;
  logic        rdenA, rdenB;
  logic [15:0] dout_in = 16'h0000;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        busy, done, aborted;
  logic [15:0] words_read;

  storage_readout #(.RD_LAT(2), .CNT_W(16)) dut (
    .rdclk(rdclk), .rst_n(rst_n), .start(start), .abort(abort),
    .chan_sel(chan_sel), .sample_count(sample_count),
    .rdenA(rdenA), .rdenB(rdenB), .dout_in(dout_in),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .busy(busy), .done(done), .aborted(aborted), .words_read(words_read)
  );

  always #5 rdclk = ~rdclk;

  logic [15:0] memA [0:63];
  logic [15:0] memB [0:63];
  int          idxA = 0;
  int          idxB = 0;
  logic [15:0] s1 = 16'h0000;

  // Storage model: FIFO read stage plus output register.
  always @(posedge rdclk) begin
    if (rdenA) begin
      s1   <= memA[idxA];
      idxA <= idxA + 1;
    end else if (rdenB) begin
      s1   <= memB[idxB];
      idxB <= idxB + 1;
    end
    dout_in <= s1;
  end

  int total = 0;
  int bad   = 0;
  int cntA, cntB, overlap, done_cnt, unstable, ready_mode, k;
  logic prev_stall;
  logic [7:0] prev_byte;
  logic [7:0] bytes_q[$];
  logic [7:0] exp_q[$];
  logic       order_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cntA = 0; cntB = 0; overlap = 0; done_cnt = 0; unstable = 0;
    prev_stall = 1'b0;
    bytes_q.delete(); exp_q.delete(); order_q.delete();
  endtask

  // One clock: sample outputs 1 time unit after the edge, then set byte_ready.
  task automatic step();
    @(posedge rdclk);
    #1;
    if (rdenA && rdenB) overlap++;
    if (rdenA) begin cntA++; order_q.push_back(1'b0); end
    if (rdenB) begin cntB++; order_q.push_back(1'b1); end
    if (done) done_cnt++;
    if (prev_stall && !abort) begin
      if (!byte_valid || byte_out !== prev_byte) unstable++;
    end
    case (ready_mode)
      1: byte_ready = ($urandom_range(0, 99) < 30);
      2: byte_ready = (bytes_q.size() < 3);
      default: ;
    endcase
    prev_stall = byte_valid && !byte_ready;
    prev_byte  = byte_out;
    if (byte_valid && byte_ready) bytes_q.push_back(byte_out);
  endtask

  task automatic drain_start(input logic [1:0] ch, input logic [15:0] n);
    chan_sel = ch; sample_count = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget);
    int c;
    c = 0;
    while (!done && c < budget) begin step(); c++; end
    chk(tag, {31'd0, done}, 32'd1);
    step(); step(); step();
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_nbytes"}, bytes_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < bytes_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {24'd0, bytes_q[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    ready_mode = 0;
    clear_stats();
    #12;
    chk("rst_busy",  {31'd0, busy},       32'd0);
    chk("rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_rden",  {30'd0, rdenA, rdenB}, 32'd0);
    chk("rst_words", {16'd0, words_read}, 32'd0);
    chk("rst_byte",  {24'd0, byte_out},   32'd0);
    #10 rst_n = 1'b1;

    // Bank A only, three words, host always ready.
    memA[idxA] = 16'h1234; memA[idxA+1] = 16'hABCD; memA[idxA+2] = 16'h00FF;
    clear_stats(); byte_ready = 1'b1;
    drain_start(2'd0, 16'd3);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    run_to_done("t1_done", 200);
    exp_q = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'hFF, 8'h00};
    check_stream("t1");
    chk("t1_cntA",  cntA, 3);
    chk("t1_cntB",  cntB, 0);
    chk("t1_words", {16'd0, words_read}, 32'd3);
    chk("t1_donecnt", done_cnt, 1);
    chk("t1_aborted", {31'd0, aborted}, 32'd0);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // Alternating banks, four words.
    memA[idxA] = 16'hA1B1; memA[idxA+1] = 16'hA3B3;
    memB[idxB] = 16'hC2D2; memB[idxB+1] = 16'hC4D4;
    clear_stats();
    drain_start(2'd2, 16'd4);
    run_to_done("t2_done", 200);
    exp_q = '{8'hB1, 8'hA1, 8'hD2, 8'hC2, 8'hB3, 8'hA3, 8'hD4, 8'hC4};
    check_stream("t2");
    chk("t2_nstrobe", order_q.size(), 4);
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      chk($sformatf("t2_order%0d", i), {31'd0, order_q[i]}, i % 2);
    chk("t2_overlap", overlap, 0);
    chk("t2_words", {16'd0, words_read}, 32'd4);

    // 30 % ready duty, eight words.
    for (int i = 0; i < 8; i++) memA[idxA+i] = {8'(2*i+1), 8'(2*i)};
    clear_stats(); ready_mode = 1;
    drain_start(2'd0, 16'd8);
    run_to_done("t3_done", 2000);
    ready_mode = 0; byte_ready = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    check_stream("t3");
    chk("t3_unstable", unstable, 0);
    chk("t3_strobes", cntA + cntB, 8);
    chk("t3_words", {16'd0, words_read}, 32'd8);

    // Zero-length drain.
    clear_stats();
    drain_start(2'd0, 16'd0);
    chk("t4_done_early", {31'd0, done}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_words", {16'd0, words_read}, 32'd0);
    step();
    chk("t4_done_pulse", {31'd0, done}, 32'd0);
    chk("t4_rden", cntA + cntB, 0);

    // Abort while the high byte of word 2 is stalled.
    memA[idxA] = 16'h5A5B; memA[idxA+1] = 16'h6C6D; memA[idxA+2] = 16'h7E7F;
    clear_stats(); ready_mode = 2;
    drain_start(2'd0, 16'd3);
    k = 0;
    while (bytes_q.size() < 3 && k < 100) begin step(); k++; end
    step(); step(); step();
    chk("t5_stall_valid", {31'd0, byte_valid}, 32'd1);
    chk("t5_stall_byte",  {24'd0, byte_out},   32'h6C);
    abort = 1'b1;
    step();
    abort = 1'b0; ready_mode = 0; byte_ready = 1'b1;
    chk("t5_valid_drop", {31'd0, byte_valid}, 32'd0);
    step();
    chk("t5_done",    {31'd0, done},    32'd1);
    chk("t5_aborted", {31'd0, aborted}, 32'd1);
    chk("t5_words",   {16'd0, words_read}, 32'd1);
    step(); step(); step();
    chk("t5_donecnt", done_cnt, 1);
    chk("t5_cntA", cntA, 2);
    chk("t5_nbytes", bytes_q.size(), 3);

    // Restart after abort on bank B.
    memB[idxB] = 16'h9192; memB[idxB+1] = 16'h9394;
    clear_stats();
    drain_start(2'd1, 16'd2);
    chk("t5r_aborted_clr", {31'd0, aborted}, 32'd0);
    run_to_done("t5r_done", 200);
    exp_q = '{8'h92, 8'h91, 8'h94, 8'h93};
    check_stream("t5r");
    chk("t5r_cntB", cntB, 2);
    chk("t5r_cntA", cntA, 0);
    chk("t5r_words", {16'd0, words_read}, 32'd2);
    chk("t5r_aborted", {31'd0, aborted}, 32'd0);

    // Asynchronous reset during WAIT of the second word.
    memA[idxA] = 16'h1122; memA[idxA+1] = 16'h3344; memA[idxA+2] = 16'h5566;
    clear_stats();
    drain_start(2'd0, 16'd3);
    k = 0;
    while (words_read != 16'd1 && k < 100) begin step(); k++; end
    chk("t6_reach", {16'd0, words_read}, 32'd1);
    step();
    #3 rst_n = 1'b0;
    #1;
    chk("t6_busy",  {31'd0, busy},       32'd0);
    chk("t6_words", {16'd0, words_read}, 32'd0);
    chk("t6_byte",  {24'd0, byte_out},   32'd0);
    chk("t6_rden",  {30'd0, rdenA, rdenB}, 32'd0);
    chk("t6_valid", {30'd0, byte_valid, done}, 32'd0);
    @(posedge rdclk);
    @(negedge rdclk);
    rst_n = 1'b1;
    clear_stats();
    step(); step(); step(); step();
    chk("t6_nodone", done_cnt, 0);
    chk("t6_idle", {31'd0, busy}, 32'd0);
    chk("t6_norden", cntA + cntB, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/storage_readout.md
Name: storage_readout

Overview:
- Downstream drain engine for the dual-bank capture storage, all on rdclk.
- Once a capture is complete, it issues single-cycle rdenA/rdenB read strobes to the storage and takes in the registered 16-bit dout.
- Each word is serialised low byte first onto an 8-bit valid/ready stream toward the host-interface FIFO.
- Reads are strictly one word at a time, so the storage FIFO is never over-read under host backpressure.

Parameters:
- RD_LAT, 2, rdclk cycles from a rden strobe to valid storage dout (FIFO read plus output register).
- CNT_W, 16, width of the word counter and of sample_count.

Ports:
- rdclk  in  1  read-domain clock; all logic is posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a drain; sampled only in IDLE.
- abort  in  1  level; terminates the drain at the next cycle boundary.
- chan_sel  in  2  0 = bank A only, 1 = bank B only, 2 = alternate A,B,A,B…, 3 = reserved (treated as 0).
- sample_count  in  CNT_W  total words to read; latched at start.
- rdenA  out  1  read strobe to storage bank A.
- rdenB  out  1  read strobe to storage bank B.
- dout_in  in  16  storage dout.
- byte_out  out  8  stream data.
- byte_valid  out  1  stream valid.
- byte_ready  in  1  stream ready from the host FIFO.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion or abort.
- aborted  out  1  held with done; high if the drain ended by abort.
- words_read  out  CNT_W  words fully transmitted in the current or last drain.

Behaviour:
- Reset values: rdenA/rdenB/byte_valid/busy/done/aborted = 0; byte_out = 0; words_read = 0; state = IDLE.
- FSM states: IDLE, ISSUE, WAIT, SEND_LO, SEND_HI, FIN.
- IDLE:
  - On start, latch sample_count into remaining and chan_sel into mode.
  - Clear words_read; set bank = B only if mode == 1, otherwise A.
  - If sample_count == 0, go to FIN; otherwise go to ISSUE.
  - start is ignored in every other state.
- ISSUE:
  - Assert exactly one of rdenA/rdenB, for exactly one cycle, according to bank.
  - Load the wait counter with RD_LAT-1; go to WAIT.
- WAIT:
  - Count down. At zero, capture dout_in into a 16-bit hold register.
  - Drive byte_out = hold[7:0] and byte_valid = 1; go to SEND_LO.
- SEND_LO:
  - Hold byte_out/byte_valid stable until byte_ready.
  - On handshake, present hold[15:8] in the next cycle; go to SEND_HI.
- SEND_HI:
  - On handshake: deassert byte_valid, increment words_read, decrement remaining.
  - In mode 2, toggle bank.
  - If remaining becomes 0, go to FIN; otherwise go to ISSUE.
- FIN: pulse done for one cycle, then IDLE.
- Strobe rules:
  - rdenA and rdenB are never high together.
  - Never more than one rden per word.
  - The next rden is issued no earlier than the cycle after the high byte is accepted.
- byte_valid rules:
  - Once asserted, byte_valid does not drop without a handshake, except on abort or reset.
  - byte_out is stable while byte_valid && !byte_ready.
- abort:
  - Any state except IDLE/FIN goes to FIN next cycle: byte_valid = 0, no further rden, aborted = 1 with done.
  - A partially sent word does not count in words_read.
  - In IDLE, abort has no effect.
  - aborted clears on the next start.
- Simultaneous events:
  - start with abort in IDLE: start wins; abort is evaluated from the next cycle.
  - abort on the same cycle as a completing SEND_HI handshake: the word counts, then FIN with aborted = 1.
- Reset mid-drain: all outputs return to reset values immediately (asynchronously); no done pulse.
- Arithmetic:
  - remaining and words_read are CNT_W unsigned, with no wrap.
  - The maximum drain is 2^CNT_W-1 words; 65535 words = 131070 bytes.

Decomposition:
- Shared readout package holds:
  - state encoding constants (3-bit);
  - chan_sel codes CH_A = 0, CH_B = 1, CH_ALT = 2;
  - default RD_LAT.
- One natural sub-module, readout_byte_ser: hold register plus the 2-byte valid/ready serialiser with a "word_accepted" pulse.
- The FSM and counters stay in storage_readout.

Test Plan:
- chan_sel = 0, sample_count = 3, byte_ready = 1, bank A model returns 0x1234/0xABCD/0x00FF.
  - Expected: bytes 34,12,CD,AB,FF,00; three rdenA pulses, no rdenB.
  - Expected: words_read = 3; done one cycle; aborted = 0.
- chan_sel = 2, sample_count = 4.
  - Expected: strobe order A,B,A,B, never overlapping; data is interleaved correctly.
- Random byte_ready at 30 % duty, sample_count = 8.
  - Expected: byte_out stable while stalled; exactly 8 rden strobes; 16 bytes in order.
- sample_count = 0.
  - Expected: no rden; done two cycles after start; words_read = 0.
- abort asserted while stalled in SEND_HI of word 2.
  - Expected: byte_valid drops; done with aborted = 1; words_read = 1; no further rden.
  - Then start again: aborted clears and the drain runs normally.
- rst_n pulsed low mid-WAIT.
  - Expected: outputs at reset values asynchronously; no done pulse; IDLE after release.
